data_mem_copy_dma: RTL and testbench

- Single-channel word-copy engine that masters the 32-bit single-port on-chip data memory (8192 words, 13-bit word address, byte enables, clock enable).
- Copies `length` words from `src_addr` to `dst_addr` using alternating read/write cycles on the memory port.
- Sits directly upstream of the data memory. A command source (CPU CSR shim or sequencer) drives start/addresses; status returns as busy/done.
- The memory registers its address under clken and returns unregistered q one cycle later. This block is built around that 1-cycle read latency.

---
 rtl/data_mem_copy_dma.sv | 119 +++++++++++
 tb/tb_data_mem_copy_dma.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_copy_dma.sv
// Single-channel word-copy DMA mastering a 1-cycle-latency single-port data memory.
// Optional running checksum of copied words: define DATA_MEM_COPY_DMA_CSUM_EN.
module data_mem_copy_dma #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [ADDR_W-1:0]     dst_addr,
   input  logic [LEN_W-1:0]      length,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [LEN_W-1:0]      words_done,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
`ifdef DATA_MEM_COPY_DMA_CSUM_EN
   ,
   output logic [DATA_W-1:0]     csum
`endif
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [LEN_W-1:0]  remaining;
   logic              abort_pend;
   logic              stop_now;

   // An abort seen in this WR cycle or any earlier RD/WR ends the copy after this write.
   assign stop_now = (remaining == LEN_W'(1)) || abort_pend || abort;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         words_done <= '0;
         aborted    <= 1'b0;
         abort_pend <= 1'b0;
`ifdef DATA_MEM_COPY_DMA_CSUM_EN
         csum       <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_ptr    <= src_addr;
                  dst_ptr    <= dst_addr;
                  remaining  <= length;
                  words_done <= '0;
                  aborted    <= 1'b0;
                  abort_pend <= 1'b0;
`ifdef DATA_MEM_COPY_DMA_CSUM_EN
                  csum       <= '0;
`endif
                  state      <= (length == '0) ? DONE : RD;
               end
            end
            RD: begin
               if (abort) abort_pend <= 1'b1;
               state <= WR;
            end
            WR: begin
               src_ptr    <= src_ptr + ADDR_W'(1);
               dst_ptr    <= dst_ptr + ADDR_W'(1);
               remaining  <= remaining - LEN_W'(1);
               words_done <= words_done + LEN_W'(1);
`ifdef DATA_MEM_COPY_DMA_CSUM_EN
               csum       <= csum + mem_readdata;
`endif
               if (stop_now) begin
                  aborted <= abort_pend | abort;
                  state   <= DONE;
               end else begin
                  state   <= RD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy           = (state == RD) || (state == WR);
   assign done           = (state == DONE);
   assign mem_byteenable = '1;
   assign mem_clken      = 1'b1;

   // Memory port follows state directly so the read word can be written back the next cycle.
   always_comb begin
      mem_address    = '0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      case (state)
         RD: begin
            mem_address    = src_ptr;
            mem_chipselect = 1'b1;
         end
         WR: begin
            mem_address    = dst_ptr;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_writedata  = mem_readdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_data_mem_copy_dma.sv
// Bench for data_mem_copy_dma: memory model, directed plus random copies checked against
// a word-by-word reference copy of the whole memory image.
module tb_data_mem_copy_dma;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [12:0] src_addr;
   logic [12:0] dst_addr;
   logic [13:0] length;
   logic        abort;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [13:0] words_done;
   logic [12:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;
`ifdef DATA_MEM_COPY_DMA_CSUM_EN
   logic [31:0] csum;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   data_mem_copy_dma dut (
      .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .length(length), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
      .words_done(words_done), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_clken(mem_clken), .mem_readdata(mem_readdata)
`ifdef DATA_MEM_COPY_DMA_CSUM_EN
      , .csum(csum)
`endif
   );

   // Single-port memory: address registered under clken, q unregistered.
   logic [31:0] mem     [0:8191];
   logic [31:0] exp_mem [0:8191];
   logic [12:0] mem_areg = '0;
   logic        fill = 1'b0;
   logic        poke_en = 1'b0;
   logic [12:0] poke_addr = '0;
   logic [31:0] poke_data = '0;

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 8192; i++) mem[i] <= $urandom;
      end else if (poke_en) begin
         mem[poke_addr] <= poke_data;
      end else if (mem_clken) begin
         mem_areg <= mem_address;
         if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
      end
   end
   assign mem_readdata = mem[mem_areg];

   task automatic check(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [12:0] a, input logic [31:0] v);
      @(posedge clk); #1;
      poke_en = 1'b1; poke_addr = a; poke_data = v;
      @(posedge clk); #1;
      poke_en = 1'b0;
      exp_mem[a] = v;
   endtask

   // restart_at/reset_at/abort_at are cycle numbers relative to the start cycle (0); <=0 means unused.
   task automatic run_cmd(input logic [12:0] s, input logic [12:0] d, input int n,
                          input int abort_at, input int restart_at, input int reset_at);
      int exp_words, exp_done_c, done_c, done_cnt, cs_cnt, rd_bad, wr_bad, rd_i, wr_i, diffs;
      logic        ab_seen;
      logic [13:0] wd_seen;
      logic [12:0] ea;
      logic [31:0] exp_sum;
      if (reset_at > 0)      exp_words = reset_at / 2;
      else if (abort_at > 0) exp_words = (abort_at + 1) / 2;
      else                   exp_words = n;
      exp_done_c = (reset_at > 0) ? -1 : 2 * exp_words + 1;
      exp_sum = '0;
      for (int i = 0; i < exp_words; i++) begin
         exp_sum = exp_sum + exp_mem[(int'(s) + i) % 8192];
         exp_mem[(int'(d) + i) % 8192] = exp_mem[(int'(s) + i) % 8192];
      end
      done_c = -1; done_cnt = 0; cs_cnt = 0; rd_bad = 0; wr_bad = 0; rd_i = 0; wr_i = 0;
      ab_seen = 1'b0; wd_seen = '0;

      @(posedge clk); #1;
      start = 1'b1; src_addr = s; dst_addr = d; length = 14'(n);
      @(negedge clk);
      check("idle_before_start", longint'({busy, done, mem_chipselect}), 0);
      for (int c = 1; c <= 2 * n + 8; c++) begin
         @(posedge clk); #1;
         start = (c == restart_at);
         if (c == restart_at) begin
            src_addr = s + 13'd50; dst_addr = d + 13'd50; length = 14'd2;
         end
         abort = (c == abort_at);
         reset = (c == reset_at);
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_c < 0) begin
               done_c = c; ab_seen = aborted; wd_seen = words_done;
            end
         end
         if (mem_chipselect) begin
            cs_cnt++;
            if (!mem_write) begin
               ea = s + 13'(rd_i);
               if (mem_address !== ea) rd_bad++;
               rd_i++;
            end else begin
               ea = d + 13'(wr_i);
               if (mem_address !== ea) wr_bad++;
               wr_i++;
            end
         end
         if (reset_at > 0 && c == reset_at + 1) begin
            check("rst_ctrl", longint'({busy, done, aborted, mem_chipselect, mem_write}), 0);
            check("rst_words_done", longint'(words_done), 0);
            check("rst_mem_address", longint'(mem_address), 0);
            check("rst_writedata", longint'(mem_writedata), 0);
         end
         if (done_c > 0 || (reset_at > 0 && c >= reset_at + 4)) break;
      end
      start = 1'b0; abort = 1'b0; reset = 1'b0;

      check("done_cycle", longint'(done_c), longint'(exp_done_c));
      check("done_pulses", longint'(done_cnt), (reset_at > 0) ? 0 : 1);
      check("mem_cycles", longint'(cs_cnt), (reset_at > 0) ? longint'(reset_at) : longint'(2 * exp_words));
      check("read_addr_seq", longint'(rd_bad), 0);
      check("write_addr_seq", longint'(wr_bad), 0);
      if (reset_at <= 0) begin
         check("words_done", longint'(wd_seen), longint'(exp_words));
         check("aborted", longint'(ab_seen), (abort_at > 0) ? 1 : 0);
`ifdef DATA_MEM_COPY_DMA_CSUM_EN
         check("csum", longint'(csum), longint'(exp_sum));
`endif
      end else begin
         check("words_done_after_reset", longint'(words_done), 0);
      end
      diffs = 0;
      for (int i = 0; i < 8192; i++) if (mem[i] !== exp_mem[i]) diffs++;
      check("mem_image", longint'(diffs), 0);
   endtask

   initial begin
      logic [12:0] rs, rd;
      int rn, ra;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; length = '0;
      @(posedge clk); #1;
      fill = 1'b1;
      @(posedge clk); #1;
      fill = 1'b0;
      for (int i = 0; i < 8192; i++) exp_mem[i] = mem[i];
      @(negedge clk);
      check("reset_ctrl", longint'({busy, done, aborted, mem_chipselect, mem_write}), 0);
      check("reset_words_done", longint'(words_done), 0);
      check("reset_mem_address", longint'(mem_address), 0);
      check("const_be_clken", longint'({mem_byteenable, mem_clken}), 32'h1f);
      @(posedge clk); #1;
      reset = 1'b0;

      poke(13'd0, 32'h11111111);
      poke(13'd1, 32'h22222222);
      poke(13'd2, 32'h33333333);
      poke(13'd3, 32'h44444444);
      run_cmd(13'd0, 13'd100, 4, -1, -1, -1);
      check("copy4_word3", longint'(mem[103]), 32'h44444444);
`ifdef DATA_MEM_COPY_DMA_CSUM_EN
      check("copy4_csum", longint'(csum), 32'hAAAAAAAA);
`endif
      run_cmd(13'd20, 13'd40, 0, -1, -1, -1);
      run_cmd(13'd8190, 13'd10, 4, -1, -1, -1);
      run_cmd(13'd200, 13'd300, 8, 5, -1, -1);
      run_cmd(13'd400, 13'd500, 6, -1, 4, 7);
      run_cmd(13'd600, 13'd700, 1, -1, -1, -1);
      run_cmd(13'd610, 13'd710, 1, -1, -1, -1);
      run_cmd(13'd800, 13'd801, 5, -1, -1, -1);

      for (int t = 0; t < 6; t++) begin
         rs = 13'($urandom_range(0, 8191));
         rd = 13'($urandom_range(0, 8191));
         rn = int'($urandom_range(1, 12));
         ra = -1;
         if (rn > 1 && $urandom_range(0, 1) == 1) ra = int'($urandom_range(1, 2 * rn - 2));
         run_cmd(rs, rd, rn, ra, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
